if_prefetch_stage: RTL

- Instruction-fetch stage with a small prefetch queue.
- Drives classic single-transfer Wishbone reads from the program counter and buffers returned {pc, instr} pairs in a FIFO.
- Presents FIFO entries to the decode stage over the core's valid/ack pipeline handshake.
- Honours pipeline flush (redirect to a new PC) and debug halt.

---
 rtl/if_prefetch_stage.sv | 132 +++++++++++++
 1 files changed

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: Wishbone single-read fetcher feeding a small
// {pc, instr, err} prefetch queue presented to decode over valid/ack.
module if_prefetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst_i,
   input  logic        flush_i,
   input  logic [31:0] pc_i,
   input  logic        halt_i,
   output logic        valid_o,
   input  logic        ack_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic        err_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic [3:0]  wb_sel_o,
   output logic [31:0] wb_adr_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i,
   input  logic        wb_err_i
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] ALIGN = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DROP
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] adr_q, adr_d;
   logic [AW-1:0] wr_q, rd_q;
   logic [CW-1:0] cnt_q;
   logic [31:0] fpc_q [DEPTH];
   logic [31:0] fins_q [DEPTH];
   logic [DEPTH-1:0] ferr_q;
   logic        term;
   logic        push;
   logic        pop;
   logic        empty;

   assign term  = wb_ack_i | wb_err_i;
   assign empty = (cnt_q == '0);
   assign valid_o = !empty && !halt_i;
   assign pop   = valid_o && ack_i && !flush_i;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      adr_d   = adr_q;
      push    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!halt_i && !flush_i && (cnt_q < FULL)) begin
               state_d = REQ;
               adr_d   = pc_q;
            end
         end
         REQ: begin
            if (term) begin
               state_d = IDLE;
               push    = !flush_i;
               pc_d    = pc_q + 32'd4;
            end else if (flush_i) begin
               state_d = DROP;
            end
         end
         DROP: begin
            if (term) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // a redirect overrides any PC advance from a completing fetch
      if (flush_i) pc_d = pc_i & ALIGN;
   end

   always_ff @(posedge clk) begin
      if (rst_i) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC & ALIGN;
         adr_q   <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         ferr_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            fpc_q[i]  <= '0;
            fins_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         adr_q   <= adr_d;
         if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
         end else begin
            if (push) begin
               fpc_q[wr_q]  <= adr_q;
               fins_q[wr_q] <= wb_err_i ? NOP : wb_dat_i;
               ferr_q[wr_q] <= wb_err_i;
               wr_q         <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            if (push && !pop) cnt_q <= cnt_q + 1'b1;
            else if (!push && pop) cnt_q <= cnt_q - 1'b1;
         end
      end
   end

   assign pc_o    = fpc_q[rd_q];
   assign instr_o = fins_q[rd_q];
   assign err_o   = ferr_q[rd_q];

   assign wb_cyc_o = (state_q != IDLE);
   assign wb_stb_o = (state_q != IDLE);
   assign wb_we_o  = 1'b0;
   assign wb_sel_o = 4'hF;
   assign wb_adr_o = adr_q;

endmodule
